// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - shared state type, default sizes and port-slicing helper for reg_file_sb
package reg_pkg;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_SWEEP = 1'b1
  } rf_state_e;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;

  // Low bit index of lane `port` inside a flattened bus of `width`-bit lanes.
  function automatic int port_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-writeback busy bits, issue gating and per-port read stall flags
module reg_scoreboard
  import reg_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              idle_i,
  input  logic              clr_all_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic              iss_en_i,
  input  logic [AW-1:0]     iss_dest_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    rd_busy_o,
  output logic              iss_ready_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             iss_acc;

  // A writeback landing on the destination this cycle frees it for a new issue.
  assign iss_ready_o = idle_i & ((iss_dest_i == '0) | ~busy_q[iss_dest_i] |
                                 (wr_en_i & (wr_addr_i == iss_dest_i)));
  assign iss_acc     = iss_en_i & iss_ready_o;

  always_comb begin
    busy_d = busy_q;
    if (clr_all_i) begin
      busy_d = '0;
    end else if (idle_i) begin
      if (wr_en_i) busy_d[wr_addr_i] = 1'b0;
      // Set after clear so a same-address issue leaves the register pending.
      if (iss_acc && (iss_dest_i != '0)) busy_d[iss_dest_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr_i[port_lo(i, AW) +: AW];
    assign rd_busy_o[i] = idle_i & busy_q[a] & ~(wr_en_i & (wr_addr_i == a)) & (a != '0);
  end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-port register file with write bypass, hazard scoreboard and bulk-clear sweep
module reg_file_sb
  import reg_pkg::*;
#(
  parameter int  XLEN  = DEF_XLEN,
  parameter int  NREGS = DEF_NREGS,
  parameter int  NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_dest,
  output logic                iss_ready,
  input  logic                clr_req,
  output logic                ready
);

  rf_state_e       state_q;
  logic [AW-1:0]   cnt_q;
  logic            ready_q;
  logic [XLEN-1:0] regs_q [NREGS];
  logic            idle;

  assign idle  = (state_q == RF_IDLE);
  assign ready = ready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      case (state_q)
        RF_IDLE: begin
          if (wr_en && (wr_addr != '0)) regs_q[wr_addr] <= wr_data;
          if (clr_req) begin
            state_q <= RF_SWEEP;
            cnt_q   <= AW'(1);
            ready_q <= 1'b0;
          end
        end
        RF_SWEEP: begin
          // Register 0 is never stored, so the sweep starts at 1.
          regs_q[cnt_q] <= '0;
          if (cnt_q == AW'(NREGS - 1)) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    assign a = rd_addr[port_lo(i, AW) +: AW];
    always_comb begin
      d = regs_q[a];
      if (a == '0)                                d = '0;
      else if (idle && wr_en && (wr_addr == a))   d = wr_data;
    end
    assign rd_data[port_lo(i, XLEN) +: XLEN] = d;
  end

  reg_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_sb (
    .clk_i       (clk),
    .rst_ni      (rst),
    .idle_i      (idle),
    .clr_all_i   (idle & clr_req),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .iss_en_i    (iss_en),
    .iss_dest_i  (iss_dest),
    .rd_addr_i   (rd_addr),
    .rd_busy_o   (rd_busy),
    .iss_ready_o (iss_ready)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed self-checking bench for reg_file_sb (default and 4-port/64-bit/16-reg builds)
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        wr_en, iss_en, clr_req, iss_ready, ready;
  logic [4:0]  wr_addr, iss_dest;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;

  logic         b_wr_en, b_iss_en, b_clr_req, b_iss_ready, b_ready;
  logic [3:0]   b_wr_addr, b_iss_dest;
  logic [63:0]  b_wr_data;
  logic [15:0]  b_rd_addr;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_busy;

  int n_checks = 0;
  int n_errors = 0;
  int cnt;

  localparam logic [63:0] D1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D2 = 64'hFEDC_BA98_7654_3210;

  always #5 clk = ~clk;

  reg_file_sb u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .iss_en(iss_en),
    .iss_dest(iss_dest), .iss_ready(iss_ready), .clr_req(clr_req), .ready(ready)
  );

  reg_file_sb #(.XLEN(64), .NREGS(16), .NRD(4)) u_dut4 (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy), .iss_en(b_iss_en),
    .iss_dest(b_iss_dest), .iss_ready(b_iss_ready), .clr_req(b_clr_req), .ready(b_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0; iss_en = 0; iss_dest = 0; clr_req = 0;
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_rd_addr = 0; b_iss_en = 0; b_iss_dest = 0;
    b_clr_req = 0;

    #2 rst = 1'b0;
    rd_addr = {5'd0, 5'd5};
    iss_dest = 5'd7;
    #1;
    chk("rst_rd0", 64'(rd_data[31:0]), 64'h0);
    chk("rst_rd1", 64'(rd_data[63:32]), 64'h0);
    chk("rst_ready", 64'(ready), 64'h1);
    chk("rst_busy", 64'(rd_busy), 64'h0);
    chk("rst_iss_ready", 64'(iss_ready), 64'h1);
    tick(); tick();
    rst = 1'b1;
    iss_dest = 0;

    // write with same-cycle bypass, then registered read
    wr_en = 1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF; rd_addr = {5'd5, 5'd3};
    #1 chk("bypass_rd0", 64'(rd_data[31:0]), 64'hDEADBEEF);
    chk("bypass_rd1_other", 64'(rd_data[63:32]), 64'h0);
    tick();
    wr_en = 0;
    #1 chk("stored_rd0", 64'(rd_data[31:0]), 64'hDEADBEEF);

    wr_en = 1; wr_addr = 5'd0; wr_data = 32'h1234; rd_addr = {5'd0, 5'd0};
    #1 chk("x0_bypass", 64'(rd_data[31:0]), 64'h0);
    tick();
    wr_en = 0;
    #1 chk("x0_stored", 64'(rd_data[63:32]), 64'h0);

    // issue marks busy; write clears it
    iss_en = 1; iss_dest = 5'd7;
    #1 chk("iss7_ready", 64'(iss_ready), 64'h1);
    tick();
    iss_en = 0; rd_addr = {5'd3, 5'd7};
    #1 chk("busy7", 64'(rd_busy), 64'b01);
    iss_en = 1;
    #1 chk("iss7_blocked", 64'(iss_ready), 64'h0);
    tick();
    iss_en = 0;
    wr_en = 1; wr_addr = 5'd7; wr_data = 32'h55;
    #1 chk("busy7_wr_same_cycle", 64'(rd_busy), 64'b00);
    chk("rd7_bypass", 64'(rd_data[31:0]), 64'h55);
    chk("iss7_ready_on_wb", 64'(iss_ready), 64'h1);
    tick();
    wr_en = 0;
    #1 chk("busy7_cleared", 64'(rd_busy), 64'b00);
    chk("rd7_stored", 64'(rd_data[31:0]), 64'h55);

    // same-address writeback and issue: data lands, busy stays
    iss_en = 1; iss_dest = 5'd9;
    tick();
    wr_en = 1; wr_addr = 5'd9; wr_data = 32'hAA;
    #1 chk("iss9_ready_wb", 64'(iss_ready), 64'h1);
    tick();
    wr_en = 0; iss_en = 0; rd_addr = {5'd0, 5'd9};
    #1 chk("rd9", 64'(rd_data[31:0]), 64'hAA);
    chk("busy9_issue_wins", 64'(rd_busy), 64'b01);
    chk("iss9_blocked", 64'(iss_ready), 64'h0);

    // fill, mark 4 busy, sweep
    for (int i = 1; i < 32; i++) begin
      wr_en = 1; wr_addr = 5'(i); wr_data = 32'(i);
      tick();
    end
    wr_en = 0;
    iss_en = 1; iss_dest = 5'd4;
    tick();
    iss_en = 0; rd_addr = {5'd31, 5'd4};
    #1 chk("busy4", 64'(rd_busy), 64'b01);
    chk("rd31_filled", 64'(rd_data[63:32]), 64'd31);
    clr_req = 1;
    #1 chk("ready_before_edge", 64'(ready), 64'h1);
    tick();
    clr_req = 0;
    wr_en = 1; wr_addr = 5'd2; wr_data = 32'hFFFF; rd_addr = {5'd4, 5'd2};
    iss_en = 1; iss_dest = 5'd5;
    #1 chk("sweep_no_bypass", 64'(rd_data[31:0]), 64'd2);
    chk("sweep_busy_zero", 64'(rd_busy), 64'b00);
    chk("sweep_iss_ready", 64'(iss_ready), 64'h0);
    cnt = 0;
    while (ready === 1'b0 && cnt < 100) begin
      cnt++;
      tick();
    end
    wr_en = 0; iss_en = 0;
    chk("sweep_len", 64'(cnt), 64'd31);
    chk("ready_after_sweep", 64'(ready), 64'h1);
    for (int a = 1; a < 32; a++) begin
      rd_addr = {5'd4, 5'(a)};
      #1 chk("sweep_zero", 64'(rd_data[31:0]), 64'h0);
    end
    rd_addr = {5'd9, 5'd4};
    iss_dest = 5'd4;
    #1 chk("busy_cleared_by_sweep", 64'(rd_busy), 64'b00);
    chk("iss4_ready_after", 64'(iss_ready), 64'h1);

    // reset in the middle of a sweep
    wr_en = 1; wr_addr = 5'd31; wr_data = 32'h99;
    tick();
    wr_en = 0; clr_req = 1;
    tick();
    clr_req = 0;
    repeat (9) tick();
    rd_addr = {5'd0, 5'd31};
    #1 chk("mid_sweep_not_yet", 64'(rd_data[31:0]), 64'h99);
    chk("mid_sweep_ready", 64'(ready), 64'h0);
    rst = 1'b0;
    #1 chk("mid_rst_ready", 64'(ready), 64'h1);
    chk("mid_rst_rd31", 64'(rd_data[31:0]), 64'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_ready", 64'(ready), 64'h1);

    // 4-port 64-bit 16-register build
    b_wr_en = 1; b_wr_addr = 4'd6; b_wr_data = D1; b_rd_addr = {4'd6, 4'd6, 4'd6, 4'd6};
    #1;
    for (int p = 0; p < 4; p++) chk("b_bypass", b_rd_data[p*64 +: 64], D1);
    tick();
    b_wr_en = 0;
    #1 chk("b_stored", b_rd_data[192 +: 64], D1);
    b_iss_en = 1; b_iss_dest = 4'd11;
    tick();
    b_iss_en = 0; b_rd_addr = {4'd6, 4'd0, 4'd11, 4'd11};
    #1 chk("b_busy11", 64'(b_rd_busy), 64'b0011);
    b_iss_en = 1;
    #1 chk("b_iss_blocked", 64'(b_iss_ready), 64'h0);
    b_wr_en = 1; b_wr_addr = 4'd11; b_wr_data = D2;
    #1 chk("b_busy_wb", 64'(b_rd_busy), 64'b0000);
    chk("b_iss_ready_wb", 64'(b_iss_ready), 64'h1);
    chk("b_bypass11", b_rd_data[0 +: 64], D2);
    chk("b_port2_x0", b_rd_data[128 +: 64], 64'h0);
    tick();
    b_wr_en = 0; b_iss_en = 0;
    #1 chk("b_busy_issue_wins", 64'(b_rd_busy), 64'b0011);
    chk("b_rd11", b_rd_data[64 +: 64], D2);
    chk("b_rd6", b_rd_data[192 +: 64], D1);
    b_clr_req = 1;
    tick();
    b_clr_req = 0;
    cnt = 0;
    while (b_ready === 1'b0 && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("b_sweep_len", 64'(cnt), 64'd15);
    chk("b_rd6_cleared", b_rd_data[192 +: 64], 64'h0);
    chk("b_busy_after_sweep", 64'(b_rd_busy), 64'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
